// File: rtl/hx711_ctrl.sv
// hx711_ctrl: HX711 load-cell ADC sequencer with gain select,
// conversion discard, box-car averaging and tare offset.
module hx711_ctrl #(
    parameter int SCK_HALF    = 50,
    parameter int TIMEOUT_CYC = 25_000_000,
    parameter int PD_CYC      = 4000,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        pwr_down,
    input  logic [1:0]  gain_sel,
    input  logic        tare,
    input  logic        Dout,
    output logic        PD_SCK,
    output logic [23:0] raw,
    output logic        raw_valid,
    output logic [23:0] net,
    output logic        net_valid,
    output logic        tare_busy,
    output logic        timeout,
    output logic        busy
);
    localparam int AW = 24 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [15:0]   HI_LAST  = 16'(SCK_HALF - 1);
    localparam logic [15:0]   LO_LAST  = 16'(2 * SCK_HALF - 1);
    localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0]   PD_LAST  = 32'(PD_CYC - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, SHIFT, DONE, PWRDN} state_t;

    state_t               state_q, state_d;
    logic                 ds1_q, dsync_q, en_q;
    logic [31:0]          timer_q, timer_d;
    logic [15:0]          hcnt_q, hcnt_d;
    logic [4:0]           pcnt_q, pcnt_d, n_q, n_d, nsel;
    logic [23:0]          sample_q, sample_d;
    logic signed [AW-1:0] acc_q, acc_d, sum;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [23:0]          off_q, off_d, avg, sat;
    logic signed [24:0]   diff;
    logic                 discard_q, discard_d, sck_q, sck_d;
    logic [23:0]          raw_q, raw_d, net_q, net_d;
    logic                 rv_q, rv_d, nv_q, nv_d;
    logic                 tbusy_q, tbusy_d, tmo_q, tmo_d;

    always_comb begin
        unique case (gain_sel)
            2'd1:    nsel = 5'd26;
            2'd2:    nsel = 5'd27;
            default: nsel = 5'd25;
        endcase
    end

    assign sum  = acc_q + AW'($signed(sample_q));
    assign avg  = 24'(sum >>> AVG_LOG2);
    assign diff = 25'($signed(avg)) - 25'($signed(off_q));
    // Overflow of the 25-bit difference shows as bit 24 != bit 23
    assign sat  = (diff[24] != diff[23]) ?
                  (diff[24] ? 24'h800000 : 24'h7FFFFF) : diff[23:0];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        n_d       = n_q;
        sample_d  = sample_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        discard_d = discard_q;
        raw_d     = raw_q;
        net_d     = net_q;
        rv_d      = 1'b0;
        nv_d      = 1'b0;
        tbusy_d   = tbusy_q;
        tmo_d     = tmo_q;
        if (en && !en_q) tmo_d = 1'b0;
        if (pwr_down && state_q != PWRDN) begin
            state_d = PWRDN;
        end else begin
            unique case (state_q)
                IDLE: if (en) state_d = WAIT_RDY;
                WAIT_RDY: begin
                    timer_d = timer_q + 32'd1;
                    if (!en) begin
                        state_d = IDLE;
                    end else if (!dsync_q) begin
                        state_d  = SHIFT;
                        n_d      = nsel;
                        hcnt_d   = '0;
                        pcnt_d   = '0;
                        sample_d = '0;
                        if (nsel != n_q) begin
                            discard_d = 1'b1;
                            acc_d     = '0;
                            cnt_d     = '0;
                        end
                    end else if (timer_q == TO_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = PWRDN;
                    end
                end
                SHIFT: begin
                    if (hcnt_q == HI_LAST && pcnt_q < 5'd24)
                        sample_d = {sample_q[22:0], dsync_q};
                    if (hcnt_q == LO_LAST) begin
                        hcnt_d = '0;
                        pcnt_d = pcnt_q + 5'd1;
                        if (pcnt_q == n_q - 5'd1) state_d = DONE;
                    end else begin
                        hcnt_d = hcnt_q + 16'd1;
                    end
                end
                DONE: begin
                    state_d = en ? WAIT_RDY : IDLE;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        raw_d = sample_q;
                        rv_d  = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            acc_d = '0;
                            cnt_d = '0;
                            nv_d  = 1'b1;
                            if (tbusy_q) begin
                                off_d   = avg;
                                tbusy_d = 1'b0;
                                net_d   = '0;
                            end else begin
                                net_d = sat;
                            end
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                PWRDN: begin
                    if (timer_q != PD_LAST) begin
                        timer_d = timer_q + 32'd1;
                    end else if (!pwr_down) begin
                        state_d   = en ? WAIT_RDY : IDLE;
                        discard_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (tare) tbusy_d = 1'b1;
        if (state_d != state_q) timer_d = '0;
        // The HX711 wakes up in A/128, so forget the previous gain
        if (state_d == PWRDN && state_q != PWRDN) begin
            acc_d = '0;
            cnt_d = '0;
            n_d   = 5'd25;
        end
        sck_d = (state_d == PWRDN) ||
                (state_d == SHIFT && hcnt_d < 16'(SCK_HALF));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ds1_q     <= 1'b1;
            dsync_q   <= 1'b1;
            en_q      <= 1'b0;
            timer_q   <= '0;
            hcnt_q    <= '0;
            pcnt_q    <= '0;
            n_q       <= 5'd25;
            sample_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            off_q     <= '0;
            discard_q <= 1'b1;
            sck_q     <= 1'b0;
            raw_q     <= '0;
            net_q     <= '0;
            rv_q      <= 1'b0;
            nv_q      <= 1'b0;
            tbusy_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ds1_q     <= Dout;
            dsync_q   <= ds1_q;
            en_q      <= en;
            timer_q   <= timer_d;
            hcnt_q    <= hcnt_d;
            pcnt_q    <= pcnt_d;
            n_q       <= n_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            off_q     <= off_d;
            discard_q <= discard_d;
            sck_q     <= sck_d;
            raw_q     <= raw_d;
            net_q     <= net_d;
            rv_q      <= rv_d;
            nv_q      <= nv_d;
            tbusy_q   <= tbusy_d;
            tmo_q     <= tmo_d;
        end
    end

    assign PD_SCK    = sck_q;
    assign raw       = raw_q;
    assign raw_valid = rv_q;
    assign net       = net_q;
    assign net_valid = nv_q;
    assign tare_busy = tbusy_q;
    assign timeout   = tmo_q;
    assign busy      = (state_q != IDLE) && (state_q != PWRDN);
endmodule

// File: tb/tb_hx711_ctrl.sv
// tb_hx711_ctrl: directed bench for hx711_ctrl with a behavioural
// HX711 serial model driven from negedge-sampled PD_SCK.
module tb_hx711_ctrl;
    localparam int SH  = 4;
    localparam int TO  = 3000;
    localparam int PDC = 100;

    logic        clk = 1'b0;
    logic        rst, en, pwr_down, tare, Dout;
    logic [1:0]  gain_sel;
    logic        PD_SCK, raw_valid, net_valid, tare_busy, timeout, busy;
    logic [23:0] raw, net;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;
    int nv_cnt = 0;
    int rv0, nv0;

    hx711_ctrl #(
        .SCK_HALF(SH), .TIMEOUT_CYC(TO), .PD_CYC(PDC), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pwr_down(pwr_down),
        .gain_sel(gain_sel), .tare(tare), .Dout(Dout),
        .PD_SCK(PD_SCK), .raw(raw), .raw_valid(raw_valid),
        .net(net), .net_valid(net_valid), .tare_busy(tare_busy),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (raw_valid) rv_cnt++;
        if (net_valid) nv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One conversion: go ready, shift d out MSB-first on PD_SCK rises
    task automatic hx_frame(input logic [23:0] d, output int np);
        logic prev;
        int   quiet, guard;
        np = 0; quiet = 0; guard = 0;
        prev = PD_SCK;
        Dout = 1'b0;
        while (quiet <= 3 * SH && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (PD_SCK && !prev) begin
                np++;
                Dout = (np <= 24) ? d[24-np] : 1'b1;
            end
            if (np > 0 && !PD_SCK) quiet++;
            else quiet = 0;
            prev = PD_SCK;
        end
        chk("frame_end", 32'(quiet > 3 * SH), 1);
    endtask

    task automatic frames(input logic [23:0] d, input int n,
                          input int exp_np, input string tag);
        int np;
        for (int i = 0; i < n; i++) begin
            hx_frame(d, np);
            chk(tag, np, exp_np);
        end
    endtask

    task automatic wait_rises(input int n);
        logic prev;
        int   r, g;
        r = 0; g = 0;
        prev = PD_SCK;
        while (r < n && g < 500) begin
            @(negedge clk);
            g++;
            if (PD_SCK && !prev) r++;
            prev = PD_SCK;
        end
        chk("rises_seen", r, n);
    endtask

    initial begin
        int g, hi;
        rst = 1'b1; en = 1'b0; pwr_down = 1'b0; gain_sel = 2'd0;
        tare = 1'b0; Dout = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sck", 32'(PD_SCK), 0);
        chk("rst_raw", 32'(raw), 0);
        chk("rst_net", 32'(net), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tare", 32'(tare_busy), 0);
        chk("rst_tmo", 32'(timeout), 0);
        rst = 1'b0; en = 1'b1;

        rv0 = rv_cnt; nv0 = nv_cnt;
        frames(24'h000100, 1, 25, "np_first");
        chk("discard_first", rv_cnt - rv0, 0);
        rv0 = rv_cnt;
        frames(24'h000100, 4, 25, "np_g0");
        chk("rv_x4", rv_cnt - rv0, 4);
        chk("raw_100", 32'(raw), 32'h100);
        chk("nv_x1", nv_cnt - nv0, 1);
        chk("net_100", 32'(net), 32'h100);

        tare = 1'b1; @(negedge clk); tare = 1'b0;
        chk("tare_busy_set", 32'(tare_busy), 1);
        nv0 = nv_cnt;
        frames(24'h000100, 4, 25, "np_tare");
        chk("tare_net", 32'(net), 0);
        chk("tare_busy_clr", 32'(tare_busy), 0);
        chk("tare_nv", nv_cnt - nv0, 1);
        frames(24'h000180, 4, 25, "np_180");
        chk("net_80", 32'(net), 32'h80);

        nv0 = nv_cnt;
        frames(24'h000180, 2, 25, "np_part");
        chk("partial_nv", nv_cnt - nv0, 0);
        gain_sel = 2'd1;
        rv0 = rv_cnt;
        frames(24'h000100, 1, 26, "np_g1");
        chk("gain_discard", rv_cnt - rv0, 0);
        frames(24'h000200, 3, 26, "np_g1b");
        chk("acc_restart", nv_cnt - nv0, 0);
        frames(24'h000200, 1, 26, "np_g1c");
        chk("acc_done", nv_cnt - nv0, 1);
        chk("net_g1", 32'(net), 32'h100);

        tare = 1'b1; @(negedge clk); tare = 1'b0;
        frames(24'h7FFFFF, 4, 26, "np_max");
        chk("sat_tare_net", 32'(net), 0);
        frames(24'h800000, 4, 26, "np_min");
        chk("net_sat", 32'(net), 32'h800000);

        gain_sel = 2'd0;
        rv0 = rv_cnt;
        frames(24'h000300, 1, 25, "np_back0");
        chk("g0_discard", rv_cnt - rv0, 0);
        frames(24'h000300, 1, 25, "np_back0b");
        chk("g0_accept", rv_cnt - rv0, 1);

        Dout = 1'b1; g = 0;
        while (!timeout && g < TO + 500) begin
            @(negedge clk);
            g++;
        end
        chk("timeout_set", 32'(timeout), 1);
        chk("to_pdsck", 32'(PD_SCK), 1);
        hi = 0;
        while (PD_SCK && hi < 2000) begin
            hi++;
            @(negedge clk);
        end
        chk("pd_hi_min", 32'(hi >= PDC), 1);
        chk("to_busy_wait", 32'(busy), 1);
        chk("to_sticky", 32'(timeout), 1);
        en = 1'b0; @(negedge clk);
        en = 1'b1; @(negedge clk); @(negedge clk);
        chk("to_clr", 32'(timeout), 0);
        rv0 = rv_cnt;
        frames(24'h000100, 1, 25, "np_to");
        chk("to_discard", rv_cnt - rv0, 0);
        frames(24'h000300, 1, 25, "np_to2");
        chk("to_accept", rv_cnt - rv0, 1);

        Dout = 1'b0;
        wait_rises(3);
        g = 0;
        while (PD_SCK && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("pd_mid_shift", 32'(busy), 1);
        rv0 = rv_cnt;
        pwr_down = 1'b1; @(negedge clk);
        chk("pd_sck_next", 32'(PD_SCK), 1);
        chk("pd_busy", 32'(busy), 0);
        Dout = 1'b1;
        repeat (20) @(negedge clk);
        pwr_down = 1'b0;
        repeat (PDC + 20) @(negedge clk);
        chk("pd_no_rv", rv_cnt - rv0, 0);
        frames(24'h000100, 1, 25, "np_pd");
        chk("pd_discard", rv_cnt - rv0, 0);
        frames(24'h000400, 1, 25, "np_pd2");
        chk("pd_accept", rv_cnt - rv0, 1);
        chk("pd_raw", 32'(raw), 32'h400);

        Dout = 1'b0;
        wait_rises(2);
        rst = 1'b1;
        #1;
        chk("arst_sck", 32'(PD_SCK), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_raw", 32'(raw), 0);
        chk("arst_net", 32'(net), 0);
        chk("arst_rv", 32'(raw_valid), 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
